// File: rtl/multi_cycle_control.sv
// Moore control FSM for a multi-cycle MIPS-style datapath; outputs decode from state (plus opcode/zero).
// Optional WAIT_STATE_EN macro: memory states stall on mem_ready_i with a 4-bit wait-counter timeout to HALT.
module multi_cycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic [2:0] alu_op_o,
  output logic [3:0] state_o,
  output logic       halt_o
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    IMM_EXEC  = 4'd10,
    IMM_WB    = 4'd11,
    HALT      = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;
  localparam logic [2:0] ALU_FN  = 3'b111;

  state_t state, state_nx;
  logic   pc_write, ir_write;
  logic   ready;
  logic   timeout;

`ifdef WAIT_STATE_EN
  logic [3:0] wait_cnt;
  logic       waiting;

  assign ready   = mem_ready_i;
  assign waiting = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  // The 15th consecutive not-ready cycle is the one that sees a count of 14.
  assign timeout = (wait_cnt == 4'd14);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
    end else if (state_nx != state) begin
      wait_cnt <= 4'd0;
    end else if (waiting && !mem_ready_i) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  logic unused_mem_ready;

  assign unused_mem_ready = mem_ready_i;
  assign ready            = 1'b1;
  assign timeout          = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    pc_src_o     = 2'b00;
    reg_dst_o    = 2'b00;
    mem_to_reg_o = 2'b00;
    alu_op_o     = ALU_ADD;
    halt_o       = 1'b0;

    case (state)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        if (ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = DECODE;
        end else if (timeout) begin
          state_nx = HALT;
        end
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          6'h00:                      state_nx = EXECUTE;
          6'h23, 6'h2B:               state_nx = MEM_ADDR;
          6'h04, 6'h05:               state_nx = BRANCH;
          6'h02, 6'h03:               state_nx = JUMP;
          6'h08, 6'h0C, 6'h0D, 6'h0F: state_nx = IMM_EXEC;
          default:                    state_nx = HALT;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_nx    = (opcode_i == 6'h2B) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (ready) begin
          state_nx = MEM_WB;
        end else if (timeout) begin
          state_nx = HALT;
        end
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 2'b01;
        state_nx     = FETCH;
      end
      MEM_WRITE: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        if (ready) begin
          state_nx = FETCH;
        end else if (timeout) begin
          state_nx = HALT;
        end
      end
      EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FN;
        state_nx    = ALU_WB;
      end
      ALU_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 2'b01;
        state_nx    = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = 2'b01;
        pc_write    = ((opcode_i == 6'h04) && zero_i) || ((opcode_i == 6'h05) && !zero_i);
        state_nx    = FETCH;
      end
      JUMP: begin
        pc_src_o = 2'b10;
        pc_write = 1'b1;
        if (opcode_i == 6'h03) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = 2'b10;
          mem_to_reg_o = 2'b10;
        end
        state_nx = FETCH;
      end
      IMM_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (opcode_i)
          6'h0C:   alu_op_o = ALU_AND;
          6'h0D:   alu_op_o = ALU_OR;
          6'h0F:   alu_op_o = ALU_LUI;
          default: alu_op_o = ALU_ADD;
        endcase
        state_nx = IMM_WB;
      end
      IMM_WB: begin
        reg_write_o = 1'b1;
        state_nx    = FETCH;
      end
      HALT: begin
        halt_o   = 1'b1;
        state_nx = HALT;
      end
      default: begin
        state_nx = HALT;
      end
    endcase
  end

  // Reset forces FETCH asynchronously; its load strobes must not fire until reset is released.
  assign pc_write_o = pc_write & reset;
  assign ir_write_o = ir_write & reset;
  assign state_o    = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: stimulus queues per-cycle expected state/controls, a negedge monitor checks them.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode_i = 6'h00;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b1;
  logic       pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_src_o, reg_dst_o, mem_to_reg_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic       halt_o;

  multi_cycle_control dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ir_write_o(ir_write_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .pc_src_o(pc_src_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .alu_op_o(alu_op_o), .state_o(state_o), .halt_o(halt_o)
  );

  always #5 clk = ~clk;

  // {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, src_a, src_b, pc_src, reg_dst, mem_to_reg, alu_op, halt}
  logic [18:0] ctl;
  assign ctl = {pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o, alu_src_a_o,
                alu_src_b_o, pc_src_o, reg_dst_o, mem_to_reg_o, alu_op_o, halt_o};

  function automatic logic [18:0] mk(input logic pw, iw, iod, mr, mw, rw, sa,
                                     input logic [1:0] sb, ps, rd, mtr,
                                     input logic [2:0] op, input logic h);
    return {pw, iw, iod, mr, mw, rw, sa, sb, ps, rd, mtr, op, h};
  endfunction

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  st;
    logic [18:0] ctl;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] next_id = 16'd0;
  int          errors = 0;
  int          checks = 0;

  logic [18:0] c_fetch, c_rst, c_dec, c_exec, c_awb, c_maddr, c_mread, c_mwb, c_mwr;
  logic [18:0] c_br_t, c_br_n, c_j, c_jal, c_iwb, c_halt;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (state_o !== e.st) begin
        errors++;
        $display("FAIL state #%0d: got %0d want %0d", e.id, state_o, e.st);
      end
      checks++;
      if (ctl !== e.ctl) begin
        errors++;
        $display("FAIL ctrl #%0d (state %0d): got %b want %b", e.id, e.st, ctl, e.ctl);
      end
    end
  end

  task automatic step(input logic [3:0] st, input logic [18:0] c);
    exp_q.push_back('{next_id, st, c});
    next_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic imm_instr(input logic [5:0] op, input logic [2:0] aop);
    opcode_i = op;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd10, mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,aop,0));
    step(4'd11, c_iwb);
  endtask

  task automatic branch_instr(input logic [5:0] op, input logic z, input logic [18:0] cbr);
    opcode_i = op;
    zero_i   = z;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd8, cbr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    c_fetch = mk(1,1,0,1,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,0);
    c_rst   = mk(0,0,0,1,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,0);
    c_dec   = mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,2'b00,3'b000,0);
    c_exec  = mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b111,0);
    c_awb   = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b00,3'b000,0);
    c_maddr = mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,3'b000,0);
    c_mread = mk(0,0,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
    c_mwb   = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0);
    c_mwr   = mk(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
    c_br_t  = mk(1,0,0,0,0,0,1,2'b00,2'b01,2'b00,2'b00,3'b001,0);
    c_br_n  = mk(0,0,0,0,0,0,1,2'b00,2'b01,2'b00,2'b00,3'b001,0);
    c_j     = mk(1,0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0);
    c_jal   = mk(1,0,0,0,0,1,0,2'b00,2'b10,2'b10,2'b10,3'b000,0);
    c_iwb   = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
    c_halt  = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1);

    // Held in reset: FETCH decode with load strobes suppressed.
    @(posedge clk);
    #1;
    step(4'd0, c_rst);
    step(4'd0, c_rst);
    reset = 1'b1;

    // R-type: 0,1,6,7 then back to 0.
    opcode_i = 6'h00;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd6, c_exec);
    step(4'd7, c_awb);

    // Load then store.
    opcode_i = 6'h23;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd2, c_maddr);
    step(4'd3, c_mread);
    step(4'd4, c_mwb);
    opcode_i = 6'h2B;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd2, c_maddr);
    step(4'd5, c_mwr);

    // Branch taken/not taken for both polarities.
    branch_instr(6'h05, 1'b1, c_br_n);
    branch_instr(6'h04, 1'b1, c_br_t);
    branch_instr(6'h04, 1'b0, c_br_n);
    branch_instr(6'h05, 1'b0, c_br_t);
    zero_i = 1'b0;

    // Jump and jump-and-link.
    opcode_i = 6'h03;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd9, c_jal);
    opcode_i = 6'h02;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd9, c_j);

    // Immediate group.
    imm_instr(6'h08, 3'b000);
    imm_instr(6'h0C, 3'b011);
    imm_instr(6'h0D, 3'b010);
    imm_instr(6'h0F, 3'b100);

    // Reset dropped in MEM_WRITE: strobe falls and state returns to FETCH without a clock.
    opcode_i = 6'h2B;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd2, c_maddr);
    exp_q.push_back('{next_id, 4'd5, c_mwr});
    next_id++;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL abort_state: got %0d want 0", state_o);
    end
    checks++;
    if ({mem_write_o, pc_write_o, ir_write_o} !== 3'b000) begin
      errors++;
      $display("FAIL abort_strobes: got %b want 000", {mem_write_o, pc_write_o, ir_write_o});
    end
    @(posedge clk);
    #1;
    step(4'd0, c_rst);
    reset = 1'b1;

    // Fetch restarts on the first edge after release.
    opcode_i = 6'h00;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd6, c_exec);
    step(4'd7, c_awb);

    // Illegal opcode halts; only reset leaves HALT.
    opcode_i = 6'h3F;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd15, c_halt);
    opcode_i = 6'h00;
    step(4'd15, c_halt);
    step(4'd15, c_halt);
    reset = 1'b0;
    step(4'd0, c_rst);
    reset = 1'b1;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);

`ifdef WAIT_STATE_EN
    step(4'd6, c_exec);
    step(4'd7, c_awb);
    // Three stall cycles in FETCH, load strobes only on the ready cycle.
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step(4'd0, c_rst);
    mem_ready_i = 1'b1;
    step(4'd0, c_fetch);
    step(4'd1, c_dec);
    step(4'd6, c_exec);
    step(4'd7, c_awb);
    // Fifteen stall cycles time out into HALT.
    mem_ready_i = 1'b0;
    for (int i = 0; i < 15; i++) step(4'd0, c_rst);
    mem_ready_i = 1'b1;
    step(4'd15, c_halt);
    step(4'd15, c_halt);
`endif

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
